serial_tx_sched: RTL
====================

Name: serial_tx_sched

Overview:
- Round-robin scheduler that shares one serial_tx instance between P_NREQ requesters.
- Latches the granted requester's word and bit count, then sequences serial_tx through a frame:
  - holds serial_tx in reset while loading;
  - generates the cnt timebase serial_tx marches to;
  - detects the frame end and enforces an idle gap.
- Sits between per-channel command logic and the serial_tx datapath.

Parameters:
- P_NREQ, 4, number of requesters (2..16).
- P_DATA_WIDTH, 32, width of each requester's data word; matches the serial_tx P_DATA_WIDTH.
- P_Y_INIT, 0, reset value of tx_y0.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  P_NREQ  per-requester level request.
- req_data  input  P_NREQ*P_DATA_WIDTH  packed data words; requester i occupies bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- req_nbits  input  P_NREQ*8  packed bit counts; requester i occupies bits [i*8 +: 8].
- y0  input  1  idle level, shared by all requesters.
- n0  input  32  start-phase cycles, shared.
- n1  input  32  cycles per bit, shared.
- n_gap  input  32  idle cycles between frames, shared.
- gnt  output  P_NREQ  one-hot; the current owner is held for the whole frame.
- done  output  P_NREQ  one-cycle pulse to the owner at frame completion.
- busy  output  1  high in every state except IDLE.
- tx_rst  output  1  reset to serial_tx.
- tx_data  output  P_DATA_WIDTH  data to serial_tx.
- tx_nbits  output  8  nbits to serial_tx.
- tx_n0  output  32  n0 to serial_tx.
- tx_n1  output  32  n1 to serial_tx.
- tx_y0  output  1  y0 to serial_tx.
- tx_cnt  output  32  cnt timebase to serial_tx.

Behaviour:
- All outputs are registered.
- Reset values: tx_rst=1, tx_cnt=0, tx_data=0, tx_nbits=1, tx_n0=1, tx_n1=1, tx_y0=P_Y_INIT, gnt=0, done=0, busy=0.
- Reset values: the round-robin pointer resets to P_NREQ-1, so requester 0 has first priority.
- States: IDLE, LOAD, RUN, GAP.

IDLE:
- tx_rst=1, tx_cnt=0.
- If req is nonzero, pick the first asserted requester searching from pointer+1 with wrap-around.
- On a pick, set gnt one-hot and latch that requester's data into tx_data.
- On a pick, latch the requester's nbits into tx_nbits, clamped: 0 becomes 1, and values above P_DATA_WIDTH become P_DATA_WIDTH.
- On a pick, latch y0, n0 and n1 into tx_y0, tx_n0 and tx_n1; n0 and n1 are clamped so 0 becomes 1.
- On a pick, set pointer to the winner and go to LOAD.

LOAD:
- Lasts exactly 2 cycles, with tx_rst=1 and tx_cnt=0, so serial_tx samples its configuration.
- Computes t_end = tx_n0 + tx_nbits*tx_n1 in 32-bit arithmetic, saturating at 0xFFFFFFFF.
- Then goes to RUN.

RUN:
- tx_rst=0; tx_cnt increments by 1 per cycle starting from 0.
- When tx_cnt == t_end, go to GAP and load gap_cnt = n_gap.

GAP:
- tx_rst=1 and tx_cnt=0, so the serial line returns to y0.
- gap_cnt decrements each cycle.
- When gap_cnt==0: pulse done[owner] for 1 cycle, clear gnt, go to IDLE.
- n_gap=0 gives a 1-cycle GAP.

Latency and fairness:
- From req sampled in IDLE to tx_rst deasserting takes 3 cycles.
- The earliest re-grant is the cycle after done.
- Simultaneous requests are resolved by round-robin; no requester waits more than P_NREQ-1 frames.

Boundary conditions:
- Changing req, req_data, req_nbits, n0, n1 or y0 after the grant has no effect on the frame in progress.
- Dropping req mid-frame does not abort the frame; done still pulses.
- n_gap is sampled on entry to GAP.
- Asserting rst mid-frame returns everything to reset values immediately, with no done pulse.
- If tx_cnt reaches 0xFFFFFFFF, it holds there; saturated t_end still terminates the frame.
- An illegal state decodes to IDLE.

Decomposition:
- Package serial_tx_pkg holds:
  - the state encoding constants (IDLE=0, LOAD=1, RUN=2, GAP=3);
  - the LOAD length constant (2);
  - the nbits clamp helper function.
- Sub-module rr_arb (P_NREQ): combinational round-robin pick from req and the pointer, producing a one-hot winner and its index.
- The serial_tx instance itself stays outside this block.

Test Plan:
- Single request, req=4'b0001, data=32'hA5, nbits=8, n0=4, n1=3, n_gap=2:
  - gnt=0001 one cycle after req;
  - tx_rst falls 3 cycles after req;
  - t_end=28, RUN lasts 29 cycles;
  - done[0] pulses after 3 GAP cycles;
  - busy falls the same cycle.
- All four requesting continuously, with n0=1, n1=1, nbits=1:
  - grant order 0,1,2,3,0;
  - each done pulse lands on the matching bit.
- Clamping, with nbits=0, n0=0, n1=0:
  - tx_nbits=1, tx_n0=1, tx_n1=1, t_end=2.
- Clamping, with nbits=200 and P_DATA_WIDTH=32:
  - tx_nbits=32.
- Owner drops req and changes req_data during RUN:
  - tx_data is unchanged;
  - the frame completes and done pulses.
- rst asserted mid-RUN, asynchronously between clock edges:
  - tx_rst=1, tx_cnt=0, gnt=0 and busy=0 immediately;
  - no done pulse;
  - the next grant goes to requester 0.
- Saturation, with n0=0xFFFFFFF0, n1=0x10, nbits=4:
  - t_end=0xFFFFFFFF;
  - the frame terminates and done pulses.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding, LOAD length and nbits clamp for serial_tx_sched
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int LOAD_LEN = 2;

    function automatic logic [7:0] clamp_nbits(input logic [7:0] nbits, input int max_bits);
        return nbits == 8'd0 ? 8'd1 : (int'(nbits) > max_bits ? 8'(max_bits) : nbits);
    endfunction

endpackage

// File: rtl/serial_tx_sched_rr_arb.sv
// rr_arb: combinational round-robin pick of the first request after the pointer
module rr_arb #(
    parameter int P_NREQ = 4
) (
    input  logic [P_NREQ-1:0]         req,
    input  logic [$clog2(P_NREQ)-1:0] ptr,
    output logic [P_NREQ-1:0]         gnt,
    output logic [$clog2(P_NREQ)-1:0] idx,
    output logic                      any
);

    localparam int W = $clog2(P_NREQ);

    // scan backwards so the last hit written is the nearest one after ptr
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = P_NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % P_NREQ]) begin
                any = 1'b1;
                idx = W'((int'(ptr) + k) % P_NREQ);
            end
        end
    end

    assign gnt = P_NREQ'(any) << idx;

endmodule

// File: rtl/serial_tx_sched.sv
// serial_tx_sched: round-robin sharing of one serial_tx between P_NREQ requesters
module serial_tx_sched
    import serial_tx_pkg::*;
#(
    parameter int   P_NREQ       = 4,
    parameter int   P_DATA_WIDTH = 32,
    parameter logic P_Y_INIT     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [P_NREQ-1:0]          req,
    input  logic [P_NREQ*P_DATA_WIDTH-1:0] req_data,
    input  logic [P_NREQ*8-1:0]        req_nbits,
    input  logic                       y0,
    input  logic [31:0]                n0,
    input  logic [31:0]                n1,
    input  logic [31:0]                n_gap,
    output logic [P_NREQ-1:0]          gnt,
    output logic [P_NREQ-1:0]          done,
    output logic                       busy,
    output logic                       tx_rst,
    output logic [P_DATA_WIDTH-1:0]    tx_data,
    output logic [7:0]                 tx_nbits,
    output logic [31:0]                tx_n0,
    output logic [31:0]                tx_n1,
    output logic                       tx_y0,
    output logic [31:0]                tx_cnt
);

    localparam int W = $clog2(P_NREQ);

    state_t              state, state_nxt;
    logic [W-1:0]        ptr, win_idx;
    logic [P_NREQ-1:0]   win_gnt;
    logic                win_any;
    logic [1:0]          load_cnt;
    logic [31:0]         t_end, gap_cnt;
    logic [40:0]         t_sum;

    rr_arb #(.P_NREQ(P_NREQ)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(win_gnt),
        .idx(win_idx),
        .any(win_any)
    );

    // wide enough that nbits*n1 + n0 never wraps before saturation
    assign t_sum = 41'(tx_n0) + 41'(tx_nbits) * 41'(tx_n1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_any ? LOAD : IDLE;
            LOAD:    state_nxt = load_cnt == 2'(LOAD_LEN - 1) ? RUN : LOAD;
            RUN:     state_nxt = tx_cnt == t_end ? GAP : RUN;
            GAP:     state_nxt = gap_cnt == 32'd0 ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= W'(P_NREQ - 1);
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            tx_rst   <= 1'b1;
            tx_data  <= '0;
            tx_nbits <= 8'd1;
            tx_n0    <= 32'd1;
            tx_n1    <= 32'd1;
            tx_y0    <= P_Y_INIT;
            tx_cnt   <= '0;
            load_cnt <= '0;
            t_end    <= '0;
            gap_cnt  <= '0;
        end else begin
            busy   <= state_nxt != IDLE;
            tx_rst <= state_nxt != RUN;
            done   <= '0;
            case (state)
                IDLE: if (win_any) begin
                    gnt      <= win_gnt;
                    ptr      <= win_idx;
                    tx_data  <= req_data[win_idx*P_DATA_WIDTH +: P_DATA_WIDTH];
                    tx_nbits <= clamp_nbits(req_nbits[win_idx*8 +: 8], P_DATA_WIDTH);
                    tx_y0    <= y0;
                    tx_n0    <= n0 == 32'd0 ? 32'd1 : n0;
                    tx_n1    <= n1 == 32'd0 ? 32'd1 : n1;
                    load_cnt <= '0;
                end
                LOAD: begin
                    load_cnt <= load_cnt + 2'd1;
                    t_end    <= |t_sum[40:32] ? '1 : t_sum[31:0];
                end
                RUN: begin
                    tx_cnt <= tx_cnt == t_end ? '0 : tx_cnt + {31'd0, ~&tx_cnt};
                    if (tx_cnt == t_end) gap_cnt <= n_gap;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 32'd1;
                    if (gap_cnt == 32'd0) begin
                        done <= gnt;
                        gnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
